// File: rtl/fu_broadcast_queue.sv
// fu_broadcast_queue: collects one-cycle done pulses from the functional
// units into per-FU capture slots, picks one slot per cycle round-robin,
// queues it in a FIFO and broadcasts one {tag, result} per cycle on the CDB.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   fu_done/tag/result   per-FU result pulse with packed tag/result buses
//   fu_queued            combinational per-FU acknowledge (captured this cycle)
//   cdb_stall            CDB cannot accept this cycle
//   cdb_valid/tag/data   broadcast entry (head of FIFO, zero when empty)
//   count/full/empty     FIFO occupancy status
//
// Optional feature: define BCQ_BYPASS_EN to let a grant into an empty,
// unstalled queue drive the CDB in the same cycle instead of being pushed.
module fu_broadcast_queue #(
    parameter int unsigned NUM_FU     = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 7,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_FU-1:0]              fu_done,
    input  logic [NUM_FU*TAG_WIDTH-1:0]    fu_tag,
    input  logic [NUM_FU*DATA_WIDTH-1:0]   fu_result,
    output logic [NUM_FU-1:0]              fu_queued,
    input  logic                           cdb_stall,
    output logic                           cdb_valid,
    output logic [TAG_WIDTH-1:0]           cdb_tag,
    output logic [DATA_WIDTH-1:0]          cdb_data,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned RR_W  = $clog2(NUM_FU);

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [NUM_FU-1:0] slot_valid;
    entry_t            slot_q [NUM_FU];
    logic [RR_W-1:0]   rr_ptr;
    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic [NUM_FU-1:0] grant;
    logic              grant_any;
    logic [RR_W-1:0]   grant_idx;
    entry_t            grant_entry;
    logic              can_accept;
    logic              pop;
    logic              push;
    logic              bypass;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Only real FIFO entries are popped; a bypassed grant never enters the FIFO.
    assign pop        = ~empty & ~cdb_stall;
    assign can_accept = ~full | pop;

`ifdef BCQ_BYPASS_EN
    assign bypass = empty & ~cdb_stall & grant_any;
`else
    assign bypass = 1'b0;
`endif

    assign push = grant_any & ~bypass;

    // Round-robin: first valid slot at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_FU) begin
                idx = idx - NUM_FU;
            end
            if (!grant_any && slot_valid[RR_W'(idx)] && can_accept) begin
                grant_any = 1'b1;
                grant_idx = RR_W'(idx);
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign grant_entry = slot_q[grant_idx];

    // A slot accepts a new result when empty or being drained this cycle.
    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            fu_queued[i] = fu_done[i] & ~rst & (~slot_valid[i] | grant[i]);
        end
    end

    // Capture slot valid bits and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            rr_ptr     <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (fu_queued[i]) begin
                    slot_valid[i] <= 1'b1;
                end else if (grant[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
            if (grant_any) begin
                rr_ptr <= (grant_idx == RR_W'(NUM_FU - 1)) ? '0 : grant_idx + RR_W'(1);
            end
        end
    end

    // Slot payload needs no reset; qualified by slot_valid.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (fu_queued[i]) begin
                slot_q[i].tag  <= fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
                slot_q[i].data <= fu_result[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= grant_entry;
        end
    end

    // CDB drive: FIFO head, else the bypassed grant, else zero.
    always_comb begin
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_data  = '0;
        if (!empty) begin
            cdb_valid = 1'b1;
            cdb_tag   = mem[head].tag;
            cdb_data  = mem[head].data;
        end else if (bypass) begin
            cdb_valid = 1'b1;
            cdb_tag   = grant_entry.tag;
            cdb_data  = grant_entry.data;
        end
    end

endmodule

// File: tb/tb_fu_broadcast_queue.sv
// Scoreboard bench for fu_broadcast_queue: directed stimulus pushes the
// expected CDB entries; an independent negedge monitor pops and compares
// every accepted broadcast.
module tb_fu_broadcast_queue;

    localparam int NUM_FU = 4;
    localparam int DW     = 32;
    localparam int TW     = 7;
    localparam int DEPTH  = 4;
`ifdef BCQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic [NUM_FU-1:0]       fu_done;
    logic [NUM_FU*TW-1:0]    fu_tag;
    logic [NUM_FU*DW-1:0]    fu_result;
    logic [NUM_FU-1:0]       fu_queued;
    logic                    cdb_stall;
    logic                    cdb_valid;
    logic [TW-1:0]           cdb_tag;
    logic [DW-1:0]           cdb_data;
    logic [$clog2(DEPTH):0]  count;
    logic                    full;
    logic                    empty;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    fu_broadcast_queue #(
        .NUM_FU(NUM_FU), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .fu_done(fu_done), .fu_tag(fu_tag), .fu_result(fu_result),
        .fu_queued(fu_queued), .cdb_stall(cdb_stall),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .count(count), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        fu_tag[i*TW +: TW]    = t;
        fu_result[i*DW +: DW] = d;
    endtask

    task automatic expect_cdb(input logic [TW-1:0] t, input logic [DW-1:0] d);
        exp_t e;
        e.tag  = t;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every accepted broadcast must match the next expected entry.
    always @(negedge clk) begin
        if (rst === 1'b0 && cdb_valid === 1'b1 && cdb_stall === 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cdb_unexpected: got tag 0x%0h data 0x%0h expected no broadcast",
                         cdb_tag, cdb_data);
            end else begin
                mon_e = sb.pop_front();
                check("cdb_tag", 64'(cdb_tag), 64'(mon_e.tag));
                check("cdb_data", 64'(cdb_data), 64'(mon_e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        rst       = 1'b1;
        fu_done   = '0;
        fu_tag    = '0;
        fu_result = '0;
        cdb_stall = 1'b0;
        tick();
        tick();

        // Reset state, with done pulses that must be ignored.
        fu_done = '1;
        @(negedge clk);
        check("queued_in_reset", 64'(fu_queued), 64'd0);
        check("count_reset", 64'(count), 64'd0);
        check("empty_reset", 64'(empty), 64'd1);
        check("full_reset", 64'(full), 64'd0);
        check("cdb_valid_reset", 64'(cdb_valid), 64'd0);
        check("cdb_tag_reset", 64'(cdb_tag), 64'd0);
        check("cdb_data_reset", 64'(cdb_data), 64'd0);
        tick();
        rst     = 1'b0;
        fu_done = '0;

        // Single FU result and latency.
        set_fu(2, 7'h15, 32'hDEADBEEF);
        fu_done = 4'b0100;
        @(negedge clk);
        check("single_queued", 64'(fu_queued), 64'h4);
        expect_cdb(7'h15, 32'hDEADBEEF);
        tick();
        fu_done = '0;
        lat = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (cdb_valid === 1'b1) begin
                lat = n;
                break;
            end
            tick();
        end
        check("single_latency", 64'(lat), 64'(LAT));
        tick();
        @(negedge clk);
        check("single_once", 64'(cdb_valid), 64'd0);
        check("single_count", 64'(count), 64'd0);

        // Round-robin with all FUs done together.
        do_reset();
        for (int i = 0; i < NUM_FU; i++) begin
            set_fu(i, 7'(16 + i), 32'hA000_0000 + 32'(i));
        end
        fu_done = '1;
        @(negedge clk);
        check("rr_queued", 64'(fu_queued), 64'hF);
        for (int i = 0; i < NUM_FU; i++) begin
            expect_cdb(7'(16 + i), 32'hA000_0000 + 32'(i));
        end
        tick();
        fu_done = '0;
        for (int n = 1; n < LAT; n++) begin
            tick();
        end
        for (int k = 0; k < NUM_FU; k++) begin
            @(negedge clk);
            check("rr_consecutive", 64'(cdb_valid), 64'd1);
            tick();
        end
        wait_drain("rr_drain");
        check("rr_ptr_end", 64'(dut.rr_ptr), 64'd0);

        // Stall until full, fifth result parked in its slot.
        do_reset();
        cdb_stall = 1'b1;
        for (int i = 0; i < NUM_FU; i++) begin
            set_fu(i, 7'(32 + i), 32'hB000_0000 + 32'(i));
        end
        fu_done = '1;
        for (int i = 0; i < NUM_FU; i++) begin
            expect_cdb(7'(32 + i), 32'hB000_0000 + 32'(i));
        end
        tick();
        fu_done = '0;
        tick();
        set_fu(0, 7'h24, 32'hB000_0024);
        fu_done = 4'b0001;
        @(negedge clk);
        check("stall_fifth_queued", 64'(fu_queued), 64'h1);
        expect_cdb(7'h24, 32'hB000_0024);
        tick();
        fu_done = '0;
        tick();
        tick();
        set_fu(0, 7'h25, 32'hB000_0025);
        fu_done = 4'b0001;
        @(negedge clk);
        check("full_count", 64'(count), 64'd4);
        check("full_flag", 64'(full), 64'd1);
        check("full_head_stable", 64'(cdb_tag), 64'h20);
        check("fifth_in_slot", 64'(dut.slot_valid[0]), 64'd1);
        check("full_slot_drop", 64'(fu_queued), 64'd0);
        tick();
        fu_done   = '0;
        cdb_stall = 1'b0;
        tick();
        // Push and pop together at full.
        @(negedge clk);
        check("pushpop_count", 64'(count), 64'd4);
        wait_drain("stall_drain");
        tick();
        tick();
        @(negedge clk);
        check("stall_empty", 64'(empty), 64'd1);

        // Reset with 3 FIFO entries and 2 valid slots.
        do_reset();
        cdb_stall = 1'b1;
        for (int i = 0; i < NUM_FU; i++) begin
            set_fu(i, 7'(48 + i), 32'hC000_0000 + 32'(i));
        end
        fu_done = '1;
        tick();
        fu_done = '0;
        tick();
        tick();
        set_fu(0, 7'h34, 32'hC000_0034);
        fu_done = 4'b0001;
        @(negedge clk);
        check("mid_queued", 64'(fu_queued), 64'h1);
        tick();
        rst     = 1'b1;
        fu_done = 4'b0010;
        @(negedge clk);
        check("mid_count_pre", 64'(count), 64'd3);
        check("mid_slots_pre", 64'(dut.slot_valid), 64'h9);
        check("mid_queued_rst", 64'(fu_queued), 64'd0);
        tick();
        rst       = 1'b0;
        fu_done   = '0;
        cdb_stall = 1'b0;
        @(negedge clk);
        check("mid_cdb_valid", 64'(cdb_valid), 64'd0);
        check("mid_count", 64'(count), 64'd0);
        check("mid_empty", 64'(empty), 64'd1);
        tick();
        set_fu(3, 7'h7F, 32'h1234_5678);
        fu_done = 4'b1000;
        @(negedge clk);
        check("post_queued", 64'(fu_queued), 64'h8);
        expect_cdb(7'h7F, 32'h1234_5678);
        tick();
        fu_done = '0;
        wait_drain("post_drain");
        tick();
        tick();
        @(negedge clk);
        check("post_empty", 64'(empty), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fu_broadcast_queue.md
Name: fu_broadcast_queue

Overview:
- Sits directly downstream of the functional units (FU_ADD, FU_XOR, …), between them and the common data bus (CDB).
- Captures each FU's one-cycle done pulse with its tag/result and returns the queued acknowledge the FU needs before it can go idle.
- Arbitrates round-robin among captured results, buffers them in a FIFO, and broadcasts one {tag, result} per cycle on the CDB.

Parameters:
- NUM_FU, 4, number of functional unit ports (≥2).
- DATA_WIDTH, 32, result width.
- TAG_WIDTH, 7, execution tag width.
- DEPTH, 4, FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fu_done  in  NUM_FU  per-FU result-valid pulse.
- fu_tag  in  NUM_FU*TAG_WIDTH  packed tags; FU i at bits [i*TAG_WIDTH +: TAG_WIDTH].
- fu_result  in  NUM_FU*DATA_WIDTH  packed results; same packing as fu_tag.
- fu_queued  out  NUM_FU  combinational acknowledge: result of FU i captured this cycle.
- cdb_stall  in  1  CDB cannot accept this cycle.
- cdb_valid  out  1  CDB entry valid.
- cdb_tag  out  TAG_WIDTH  broadcast tag.
- cdb_data  out  DATA_WIDTH  broadcast result.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset values: all slots invalid, FIFO empty, rr_ptr=0, count=0, full=0, empty=1, cdb_valid=0, cdb_tag=0, cdb_data=0. fu_queued=0 while rst is high.
- Capture slots: one {valid, tag, result} slot per FU.
  - fu_queued[i] = fu_done[i] & ~rst & (~slot_valid[i] | grant[i]).
  - When fu_queued[i] is high, the slot loads fu_tag/fu_result at the edge.
  - done with the slot full and not granted: fu_queued[i]=0 and the pulse is dropped; the FU stays busy (its contract).
- Arbiter: among valid slots, grant the first index ≥ rr_ptr, wrapping modulo NUM_FU.
  - A grant is issued only if the FIFO can accept: ~full | pop.
  - On a grant, rr_ptr ← (granted index + 1) mod NUM_FU, and the granted slot clears (or reloads if the same FU is queued that cycle).
  - At most one grant per cycle.
- FIFO:
  - push = grant (minus bypass, see Optional Feature).
  - pop = cdb_valid & ~cdb_stall.
  - Simultaneous push+pop at full is legal; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - Writes to the tail slot, reads from the head slot.
- CDB output:
  - cdb_valid = ~empty; cdb_tag/cdb_data = head entry.
  - While cdb_stall is high, the head holds stable.
  - When empty, cdb_tag/cdb_data are driven 0.
- Latency, no stall, empty FIFO:
  - done in cycle T → slot valid at T+1, granted at T+1 → cdb_valid at T+2.
  - Each result is broadcast exactly once.
- Ordering: FIFO order equals grant order; no ordering across FUs beyond round-robin.
- Reset mid-operation: all pending slots and FIFO contents are discarded; the next cycle behaves as post-reset.

Optional Feature:
- Macro: BCQ_BYPASS_EN.
- Defined:
  - When the FIFO is empty, cdb_stall=0, and a grant occurs, the granted slot drives cdb_valid/tag/data combinationally that cycle and is not pushed.
  - Latency done→cdb_valid becomes 1 cycle (T+1).
  - When empty is high, the cdb_* outputs mux the grant path.
- Not defined: all grants push into the FIFO; latency is 2 cycles.

Test Plan:
- Single FU: reset, fu_done[2]=1 for one cycle with tag=0x15, result=0xDEADBEEF → fu_queued[2]=1 that cycle. cdb_valid=1 with tag 0x15 and data 0xDEADBEEF exactly 2 cycles later (1 with BCQ_BYPASS_EN), for one cycle; count returns to 0.
- Round-robin: all four FUs pulse done together with tags 0x10..0x13 → all fu_queued=1. CDB order is 0x10, 0x11, 0x12, 0x13 on consecutive cycles; rr_ptr ends at 0.
- Stall/full, DEPTH=4: cdb_stall=1 while 5 results arrive → count reaches 4, full=1, the 5th stays in its slot. A further done on that same FU gets fu_queued=0. Release the stall → 5 broadcasts in order with no loss or duplicates.
- Full with push+pop: FIFO full, cdb_stall=0, one slot valid → grant and pop in the same cycle; count stays 4 and the head advances.
- Reset mid-operation: 3 entries in FIFO plus 2 valid slots, assert rst for 1 cycle → cdb_valid=0, count=0, empty=1 next cycle. A subsequent done with tag 0x7F broadcasts normally.
